// File: rtl/relay_buf_pkg.sv
// relay_pkg: shared constants, types and helpers for the relay elastic buffer.
//   RELAY_WIDTH  - default data width
//   relay_data_t - signed data word at the default width
//   relay_cw()   - occupancy counter width able to hold 0..depth
package relay_pkg;

  localparam int unsigned RELAY_WIDTH = 32;

  typedef logic signed [RELAY_WIDTH-1:0] relay_data_t;

  function automatic int unsigned relay_cw(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/relay_buf_if.sv
// relay_buf_if: producer/consumer handshake bundle around the relay buffer.
//   in, in_valid - upstream data and valid (driven by master)
//   delay_       - stall to upstream (driven by the buffer)
//   out, valid   - head-of-buffer data and valid (driven by the buffer)
//   _delay       - stall from downstream (driven by master)
// The master modport is the environment side; the slave modport is the buffer.
interface relay_buf_if #(
  parameter int unsigned WIDTH = relay_pkg::RELAY_WIDTH
);
  logic signed [WIDTH-1:0] in;
  logic                    in_valid;
  logic                    delay_;
  logic signed [WIDTH-1:0] out;
  logic                    valid;
  logic                    _delay;

  modport master (
    output in, in_valid, _delay,
    input  delay_, out, valid
  );

  modport slave (
    input  in, in_valid, _delay,
    output delay_, out, valid
  );
endinterface

// File: rtl/relay_buf_ram.sv
// relay_ram: DEPTH x WIDTH register array storage for the relay buffer.
//   clk   - rising-edge clock
//   we    - write enable; waddr/wdata written on the rising edge
//   raddr - asynchronous read address; rdata reflects mem[raddr] immediately
// The array has no reset; contents are qualified by the buffer's occupancy.
module relay_ram #(
  parameter int unsigned WIDTH = relay_pkg::RELAY_WIDTH,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [AW-1:0]           waddr,
  input  logic signed [WIDTH-1:0] wdata,
  input  logic [AW-1:0]           raddr,
  output logic signed [WIDTH-1:0] rdata
);

  logic signed [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/relay_buf.sv
// relay_buf: elastic FIFO of DEPTH signed entries between pipeline stages.
//   clk    - rising-edge clock
//   reset  - asynchronous active-low reset (drops all entries)
//   enable - stage enable; when low all state is frozen and both sides stall
//   flush  - synchronous clear of all entries (needs enable), beats push/pop
//   bus    - handshake bundle (slave side): in/in_valid/delay_ upstream,
//            out/valid/_delay downstream
//   count  - current occupancy, 0..DEPTH
// DEPTH must be a power of 2 and at least 2 so the pointers wrap naturally.
module relay_buf
  import relay_pkg::*;
#(
  parameter int unsigned WIDTH = RELAY_WIDTH,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW   = relay_cw(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            flush,
  relay_buf_if.slave      bus,
  output logic [CW-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic                    empty;
  logic                    full;
  logic                    push;
  logic                    pop;
  logic                    clear;
  logic signed [WIDTH-1:0] rdata;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // Upstream stall depends on registered occupancy only, never on _delay,
  // so a full buffer refuses input even in a cycle where it also pops.
  assign bus.delay_ = ~enable | full;
  assign bus.valid  = enable & ~empty;
  assign bus.out    = empty ? '0 : rdata;

  assign clear = enable & flush;
  assign push  = enable & bus.in_valid & ~full;
  assign pop   = bus.valid & ~bus._delay;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  relay_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push & ~clear),
    .waddr (wr_ptr_q),
    .wdata (bus.in),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  assign count = count_q;

endmodule

// File: tb/tb_relay_buf.sv
// Self-checking bench for relay_buf (WIDTH=8, DEPTH=4). A queue model holds
// accepted data; every cycle the DUT outputs are compared against it.
module tb_relay_buf;
  import relay_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 4;
  localparam int unsigned CW = relay_cw(D);

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          flush;
  logic [CW-1:0] count;

  relay_buf_if #(.WIDTH(W)) bus ();

  relay_buf #(.WIDTH(W), .DEPTH(D)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .flush  (flush),
    .bus    (bus),
    .count  (count)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic signed [W-1:0] sb_q[$];
  logic                last_push;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare all outputs against the model mid-cycle, then advance the model
  // on the rising edge using the inputs currently driven.
  task automatic cycle();
    logic        do_push, do_pop;
    logic [31:0] exp_out;
    @(negedge clk);
    exp_out = (sb_q.size() != 0) ? 32'(unsigned'(sb_q[0])) : 32'd0;
    check("valid",  32'(bus.valid),  32'(enable && sb_q.size() != 0));
    check("delay_", 32'(bus.delay_), 32'(!enable || sb_q.size() == D));
    check("count",  32'(count),      32'(sb_q.size()));
    check("out",    32'(unsigned'(bus.out)), exp_out);
    do_push = reset && enable && !flush && bus.in_valid && (sb_q.size() != D);
    do_pop  = reset && enable && !flush && !bus._delay && (sb_q.size() != 0);
    @(posedge clk);
    if (!reset || (enable && flush)) begin
      sb_q.delete();
    end else begin
      if (do_pop)  void'(sb_q.pop_front());
      if (do_push) sb_q.push_back(bus.in);
    end
    last_push = do_push;
    #1;
  endtask

  task automatic push_item(input int v);
    bus.in       = W'(v);
    bus.in_valid = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input int unsigned n);
    bus.in_valid = 1'b0;
    bus._delay   = 1'b0;
    for (int unsigned i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int unsigned guard;
    reset        = 1'b0;
    enable       = 1'b1;
    flush        = 1'b0;
    bus.in       = '0;
    bus.in_valid = 1'b0;
    bus._delay   = 1'b0;
    last_push    = 1'b0;
    #1;

    // Reset then idle
    for (int i = 0; i < 3; i++) cycle();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) cycle();

    // Streaming with no stall
    for (int v = 1; v <= 5; v++) push_item(v);
    drain(2);

    // Fill and backpressure
    bus._delay = 1'b1;
    push_item(10); push_item(-20); push_item(30); push_item(-40);
    bus.in = 8'd50; bus.in_valid = 1'b1;
    cycle();
    check("fill_count",  32'(count), 32'd4);
    check("fill_delay_", 32'(bus.delay_), 32'd1);
    bus._delay = 1'b0;
    cycle();
    check("no_push_at_full", 32'(last_push), 32'd0);
    guard = 0;
    while (!last_push && guard < 10) begin
      cycle();
      guard++;
    end
    check("push50_after_pop", guard, 32'd1);
    drain(6);

    // Simultaneous push/pop at count 2 across pointer wrap
    bus._delay = 1'b1;
    push_item(100); push_item(101);
    bus._delay = 1'b0;
    for (int v = 102; v < 112; v++) begin
      push_item(v);
      check("steady_count", 32'(count), 32'd2);
    end
    drain(4);

    // Flush with a concurrent push at count 3
    bus._delay = 1'b1;
    push_item(-1); push_item(-2); push_item(-3);
    flush = 1'b1;
    push_item(99);
    flush = 1'b0;
    check("flush_count", 32'(count), 32'd0);
    check("flush_valid", 32'(bus.valid), 32'd0);
    bus._delay = 1'b0;
    push_item(7);
    check("after_flush_out", 32'(unsigned'(bus.out)), 32'h07);
    drain(3);

    // Enable low freezes state
    bus._delay = 1'b1;
    push_item(33); push_item(44);
    enable = 1'b0;
    bus.in = 8'd55; bus.in_valid = 1'b1; bus._delay = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    check("frozen_count", 32'(count), 32'd2);
    enable = 1'b1; bus.in_valid = 1'b0; bus._delay = 1'b1;
    cycle();
    check("reenable_head", 32'(unsigned'(bus.out)), 32'h21);

    // Asynchronous reset mid-cycle
    #1 reset = 1'b0;
    #1;
    check("async_valid", 32'(bus.valid), 32'd0);
    check("async_count", 32'(count), 32'd0);
    check("async_out",   32'(unsigned'(bus.out)), 32'd0);
    sb_q.delete();
    cycle();
    reset = 1'b1;
    drain(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
